// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - uop codes, exception bit positions and LSU state encodings.
package lsu_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int ALU_OP_BUS   = 8;

    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_LB  = 8'h10;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_LH  = 8'h11;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_LW  = 8'h12;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_LBU = 8'h13;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_LHU = 8'h14;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_SB  = 8'h18;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_SH  = 8'h19;
    localparam logic [ALU_OP_BUS-1:0] UOP_CODE_SW  = 8'h1A;

    localparam int EXCEPT_LOAD_MISALIGN      = 4;
    localparam int EXCEPT_LOAD_ACCESS_FAULT  = 5;
    localparam int EXCEPT_STORE_MISALIGN     = 6;
    localparam int EXCEPT_STORE_ACCESS_FAULT = 7;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2,
        LSU_DRAIN    = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic       is_mem;
        logic       is_load;
        logic [1:0] size;
        logic       sext;
    } uop_info_t;

    function automatic uop_info_t decode_uop(input logic [ALU_OP_BUS-1:0] uop);
        uop_info_t info;
        info = '0;
        case (uop)
            UOP_CODE_LB:  info = '{1'b1, 1'b1, SZ_B, 1'b1};
            UOP_CODE_LH:  info = '{1'b1, 1'b1, SZ_H, 1'b1};
            UOP_CODE_LW:  info = '{1'b1, 1'b1, SZ_W, 1'b0};
            UOP_CODE_LBU: info = '{1'b1, 1'b1, SZ_B, 1'b0};
            UOP_CODE_LHU: info = '{1'b1, 1'b1, SZ_H, 1'b0};
            UOP_CODE_SB:  info = '{1'b1, 1'b0, SZ_B, 1'b0};
            UOP_CODE_SH:  info = '{1'b1, 1'b0, SZ_H, 1'b0};
            UOP_CODE_SW:  info = '{1'b1, 1'b0, SZ_W, 1'b0};
            default:      info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_sext_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o        = 4'b1111;
        bus_wdata_o = st_data_i;
        case (st_size_i)
            SZ_B: begin
                be_o        = 4'b0001 << st_off_i;
                bus_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                be_o        = 4'b0011 << st_off_i;
                bus_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = shifted;
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{ld_sext_i & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data_o = {{16{ld_sext_i & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - memory-stage load/store unit; LSU_BUS_ERR_EN enables bus-error access faults.
module lsu
    import lsu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    n_rst_i,
    input  logic                    flush_i,
    input  logic                    rd_we_i,
    input  logic [REG_ADDR_BUS-1:0] rd_addr_i,
    input  logic [REG_BUS-1:0]      rd_wdata_i,
    input  logic [ALU_OP_BUS-1:0]   uop_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             mem_wdata_i,
    input  logic                    csr_we_i,
    input  logic [31:0]             csr_waddr_i,
    input  logic [31:0]             csr_wdata_i,
    input  logic [31:0]             exception_i,
    output logic                    rd_we_o,
    output logic [REG_ADDR_BUS-1:0] rd_addr_o,
    output logic [REG_BUS-1:0]      rd_wdata_o,
    output logic                    csr_we_o,
    output logic [31:0]             csr_waddr_o,
    output logic [31:0]             csr_wdata_o,
    output logic [31:0]             exception_o,
    output logic                    stall_req_o,
    output logic                    dbus_req_o,
    output logic                    dbus_we_o,
    output logic [31:0]             dbus_addr_o,
    output logic [3:0]              dbus_be_o,
    output logic [31:0]             dbus_wdata_o,
    input  logic                    dbus_gnt_i,
    input  logic                    dbus_rvalid_i,
    input  logic                    dbus_err_i,
    input  logic [31:0]             dbus_rdata_i
);

    lsu_state_e                state_q, state_d;
    logic [1:0]                off_q, off_d;
    logic [ALU_OP_BUS-1:0]     uop_q, uop_d;
    logic [REG_ADDR_BUS-1:0]   rd_addr_q, rd_addr_d;
    logic                      we_q, we_d;

    uop_info_t   info, ld_info;
    logic        misalign, issue_ok, bus_drive, bus_err, unused_bits;
    logic [3:0]  be;
    logic [31:0] bus_wdata, ld_data;

    assign info    = decode_uop(uop_i);
    assign ld_info = decode_uop(uop_q);

    assign misalign = info.is_mem &&
                      (((info.size == SZ_H) && mem_addr_i[0]) ||
                       ((info.size == SZ_W) && (mem_addr_i[1:0] != 2'b00)));
    assign issue_ok = info.is_mem && !misalign && (exception_i == '0) && !flush_i;

`ifdef LSU_BUS_ERR_EN
    assign bus_err     = dbus_err_i;
    assign unused_bits = info.sext ^ ld_info.is_mem;
`else
    assign bus_err     = 1'b0;
    assign unused_bits = info.sext ^ ld_info.is_mem ^ dbus_err_i;
`endif

    lsu_align u_align (
        .st_size_i   (info.size),
        .st_off_i    (mem_addr_i[1:0]),
        .st_data_i   (mem_wdata_i),
        .be_o        (be),
        .bus_wdata_o (bus_wdata),
        .ld_size_i   (ld_info.size),
        .ld_sext_i   (ld_info.sext),
        .ld_off_i    (off_q),
        .rdata_i     (dbus_rdata_i),
        .ld_data_o   (ld_data)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q   <= LSU_IDLE;
            off_q     <= '0;
            uop_q     <= '0;
            rd_addr_q <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            uop_q     <= uop_d;
            rd_addr_q <= rd_addr_d;
            we_q      <= we_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        uop_d        = uop_q;
        rd_addr_d    = rd_addr_q;
        we_d         = we_q;
        bus_drive    = 1'b0;
        rd_we_o      = rd_we_i;
        rd_addr_o    = rd_addr_i;
        rd_wdata_o   = rd_wdata_i;
        csr_we_o     = csr_we_i;
        csr_waddr_o  = csr_waddr_i;
        csr_wdata_o  = csr_wdata_i;
        exception_o  = exception_i;
        stall_req_o  = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = '0;
        dbus_be_o    = '0;
        dbus_wdata_o = '0;

        case (state_q)
            LSU_IDLE: begin
                if (misalign) begin
                    rd_we_o = 1'b0;
                    if (info.is_load) exception_o[EXCEPT_LOAD_MISALIGN] = 1'b1;
                    else              exception_o[EXCEPT_STORE_MISALIGN] = 1'b1;
                end else if (info.is_mem) begin
                    // A memory uop that is not issued never writes back.
                    rd_we_o = 1'b0;
                    if (issue_ok) begin
                        stall_req_o = 1'b1;
                        bus_drive   = 1'b1;
                        off_d       = mem_addr_i[1:0];
                        uop_d       = uop_i;
                        rd_addr_d   = rd_addr_i;
                        we_d        = rd_we_i;
                        state_d     = dbus_gnt_i ? LSU_WAIT_RSP : LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                stall_req_o = 1'b1;
                if (flush_i) begin
                    state_d = LSU_IDLE;
                end else begin
                    bus_drive = 1'b1;
                    if (dbus_gnt_i) state_d = LSU_WAIT_RSP;
                end
            end
            LSU_WAIT_RSP: begin
                stall_req_o = 1'b1;
                if (dbus_rvalid_i) begin
                    state_d = LSU_IDLE;
                    // A flush landing on the response cycle simply drops it.
                    if (!flush_i) begin
                        stall_req_o = 1'b0;
                        rd_addr_o   = rd_addr_q;
                        rd_we_o     = ld_info.is_load && we_q && !bus_err;
                        if (ld_info.is_load) rd_wdata_o = ld_data;
                        if (bus_err) begin
                            if (ld_info.is_load) exception_o[EXCEPT_LOAD_ACCESS_FAULT] = 1'b1;
                            else                 exception_o[EXCEPT_STORE_ACCESS_FAULT] = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    state_d = LSU_DRAIN;
                end
            end
            LSU_DRAIN: begin
                stall_req_o = 1'b1;
                if (dbus_rvalid_i) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase

        if (bus_drive) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = !info.is_load;
            dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
            dbus_be_o    = be;
            dbus_wdata_o = bus_wdata;
        end

        if (stall_req_o) begin
            rd_we_o     = 1'b0;
            csr_we_o    = 1'b0;
            exception_o = '0;
        end

        // Outputs read as zero for the whole time reset is asserted.
        if (!n_rst_i) begin
            rd_we_o      = 1'b0;
            rd_addr_o    = '0;
            rd_wdata_o   = '0;
            csr_we_o     = 1'b0;
            csr_waddr_o  = '0;
            csr_wdata_o  = '0;
            exception_o  = '0;
            stall_req_o  = 1'b0;
            dbus_req_o   = 1'b0;
            dbus_we_o    = 1'b0;
            dbus_addr_o  = '0;
            dbus_be_o    = '0;
            dbus_wdata_o = '0;
        end
    end

endmodule
